lsu_mem_port: RTL and testbench

- Load/store unit sitting between the register file and the data-memory bus.
- Consumes base register, offset and store data from the register file, and runs one memory transaction per instruction with a req/ack handshake.
- Returns right-aligned load data with a one-cycle `load_flag` write-enable pulse to the register file.
- Sign/zero extension of loads stays in the register file; this block only selects and aligns lanes.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_mem_port_lane_align.sv | 51 +++++
 rtl/lsu_mem_port.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the lsu_mem_port load/store unit.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Loads reject 3/6/7; stores only accept B/H/W.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    else         return (f3 <= 3'd2);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Combinational lane steering: right-aligns load data and replicates/strobes store data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // funct3[1:0] alone picks the width; the unsigned bit only matters to the register file.
  always_comb begin
    o_load_data = i_rdata;
    o_wdata     = i_store_data;
    o_wstrb     = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        o_load_data = {24'b0, w_byte};
        o_wdata     = {4{i_store_data[7:0]}};
        o_wstrb     = 4'b0001 << i_off;
      end
      2'b01: begin
        o_load_data = {16'b0, w_half};
        o_wdata     = {2{i_store_data[15:0]}};
        o_wstrb     = i_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_load_data = i_rdata;
        o_wdata     = i_store_data;
        o_wstrb     = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: one req/ack bus transaction per load/store instruction.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned half/word accesses instead of aligning them.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [31:0]       base,
  input  logic [11:0]       imm12,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              load_flag,
  output logic              done,
  output logic              fault,
  output logic [31:0]       reg_load,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output lsu_state_t        o_dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  // Handshake: mem_req rises one edge after an accepted start and stays high, with
  // address/we/wdata/wstrb stable, until a cycle where mem_ack=1 or the timeout expires.

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_load;
  logic              r_fault;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [31:0]       r_reg_load;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_wstrb;

  logic        w_is_load;
  logic        w_is_store;
  logic [31:0] w_ea;
  logic [1:0]  w_off;
  logic        w_misalign;
  logic        w_bad;
  logic [2:0]  w_al_f3;
  logic [1:0]  w_al_off;
  logic [31:0] w_al_load;
  logic [31:0] w_al_wdata;
  logic [3:0]  w_al_wstrb;

  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);
  assign w_ea       = base + {{20{imm12[11]}}, imm12};
  assign w_off      = w_ea[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(funct3, w_off);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_bad = !f3_legal(w_is_load, funct3) || w_misalign;

  // The aligner sees the incoming instruction in IDLE and the captured one afterwards.
  assign w_al_f3  = (r_state == ST_IDLE) ? funct3 : r_f3;
  assign w_al_off = (r_state == ST_IDLE) ? w_off  : r_off;

  lsu_lane_align u_align (
    .i_funct3     (w_al_f3),
    .i_off        (w_al_off),
    .i_store_data (store_data),
    .i_rdata      (mem_rdata),
    .o_load_data  (w_al_load),
    .o_wdata      (w_al_wdata),
    .o_wstrb      (w_al_wstrb)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_is_load   <= 1'b0;
      r_fault     <= 1'b0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      r_reg_load  <= 32'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (start && (w_is_load || w_is_store)) begin
            r_is_load <= w_is_load;
            r_f3      <= funct3;
            r_off     <= w_off;
            if (w_bad) begin
              r_fault <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_fault     <= 1'b0;
              r_mem_addr  <= {w_ea[ADDR_W-1:2], 2'b00};
              r_mem_we    <= w_is_store;
              r_mem_wdata <= w_is_store ? w_al_wdata : 32'd0;
              r_mem_wstrb <= w_is_store ? w_al_wstrb : 4'd0;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (r_is_load) r_reg_load <= w_al_load;
            r_state <= ST_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_fault <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign mem_req     = (r_state == ST_REQ);
  assign done        = (r_state == ST_DONE);
  assign fault       = done && r_fault;
  assign load_flag   = done && r_is_load && !r_fault;
  assign reg_load    = r_reg_load;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;
  assign o_dbg_state = lsu_state_t'(r_state);

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed, table-driven bench for lsu_mem_port with hand-computed expectations.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [11:0] imm12;
  logic [31:0] store_data;
  logic        busy, load_flag, done, fault;
  logic [31:0] reg_load;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  lsu_state_t  dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cur_load;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  lsu_mem_port #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .opcode     (opcode),
    .funct3     (funct3),
    .base       (base),
    .imm12      (imm12),
    .store_data (store_data),
    .busy       (busy),
    .load_flag  (load_flag),
    .done       (done),
    .fault      (fault),
    .reg_load   (reg_load),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .o_dbg_state(dbg_state)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] imm;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack_cyc;
    int          exp_req_cyc;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_fault;
    logic        exp_load;
    logic [31:0] exp_rl;
    logic        poke;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] b,
                              input logic [11:0] imm, input logic [31:0] sd, input logic [31:0] rd,
                              input int ack_cyc, input int req_cyc, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic flt, input logic ld, input logic [31:0] rl,
                              input logic poke);
    vec_t v;
    v.op = op; v.f3 = f3; v.base = b; v.imm = imm; v.sd = sd; v.rdata = rd;
    v.ack_cyc = ack_cyc; v.exp_req_cyc = req_cyc; v.exp_addr = addr; v.exp_we = we;
    v.exp_wdata = wdata; v.exp_wstrb = wstrb; v.exp_fault = flt; v.exp_load = ld;
    v.exp_rl = rl; v.poke = poke;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver + scoreboard for one instruction
  task automatic run_vec(input int idx, input vec_t v);
    int    req_cyc;
    int    guard;
    string tag;
    tag = $sformatf("v%0d", idx);
    opcode = v.op; funct3 = v.f3; base = v.base; imm12 = v.imm; store_data = v.sd;
    start = 1'b1;
    if (v.exp_load) exp_q.push_back(v.exp_rl);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_req_latency"}, {31'b0, mem_req}, {31'b0, (v.exp_req_cyc > 0)});
    req_cyc = 0;
    guard   = 0;
    while (!done && guard < 20) begin
      chk({tag, "_req_hold"}, {31'b0, mem_req}, 32'd1);
      chk({tag, "_addr"}, mem_addr, v.exp_addr);
      chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, v.exp_we});
      chk({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, v.exp_wstrb});
      if (v.exp_we) chk({tag, "_wdata"}, mem_wdata, v.exp_wdata);
      req_cyc++;
      if (req_cyc == v.ack_cyc) begin
        mem_ack = 1'b1;
        mem_rdata = v.rdata;
      end
      if (v.poke && req_cyc == 2) begin
        start = 1'b1; opcode = OP_STORE; funct3 = F3_W; base = 32'h5000;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      start = 1'b0;
      guard++;
    end
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_req_cycles"}, req_cyc, v.exp_req_cyc);
    chk({tag, "_fault"}, {31'b0, fault}, {31'b0, v.exp_fault});
    chk({tag, "_load_flag"}, {31'b0, load_flag}, {31'b0, v.exp_load});
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
    chk({tag, "_req_off"}, {31'b0, mem_req}, 32'd0);
    if (v.exp_load && exp_q.size() > 0) cur_load = exp_q.pop_front();
    chk({tag, "_reg_load"}, reg_load, cur_load);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_idle_req"}, {31'b0, mem_req}, 32'd0);
    if (v.poke) begin
      @(posedge clk); #1;
      chk({tag, "_ignored_start"}, {31'b0, busy | mem_req}, 32'd0);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; opcode = '0; funct3 = '0; base = '0; imm12 = '0;
    store_data = '0; mem_ack = 1'b0; mem_rdata = '0; cur_load = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {busy, load_flag, done, fault, mem_req, mem_we, mem_wstrb}, 32'd0);
    chk("rst_reg_load", reg_load, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = mk(OP_STORE, F3_W,  32'h1000,     12'h004, 32'hDEADBEEF, 32'h0,        3, 3,  32'h1004,     1, 32'hDEADBEEF, 4'b1111, 0, 0, 32'h0,        0);
    vecs[1]  = mk(OP_LOAD,  F3_B,  32'h2003,     12'h000, 32'h0,        32'h88776655, 1, 1,  32'h2000,     0, 32'h0,        4'b0000, 0, 1, 32'h00000088, 0);
    vecs[2]  = mk(OP_STORE, F3_B,  32'h10,       12'hFFF, 32'h000000AB, 32'h0,        2, 2,  32'h0C,       1, 32'hABABABAB, 4'b1000, 0, 0, 32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[3]  = mk(OP_LOAD,  F3_H,  32'h101,      12'h000, 32'h0,        32'hCAFEF00D, 0, 0,  32'h0,        0, 32'h0,        4'b0000, 1, 0, 32'h0,        0);
`else
    vecs[3]  = mk(OP_LOAD,  F3_H,  32'h101,      12'h000, 32'h0,        32'hCAFEF00D, 1, 1,  32'h100,      0, 32'h0,        4'b0000, 0, 1, 32'h0000F00D, 0);
`endif
    vecs[4]  = mk(OP_LOAD,  F3_W,  32'h3000,     12'h008, 32'h0,        32'h0,        0, TO, 32'h3008,     0, 32'h0,        4'b0000, 1, 0, 32'h0,        1);
    vecs[5]  = mk(OP_LOAD,  F3_HU, 32'h2002,     12'h000, 32'h0,        32'h12345678, 2, 2,  32'h2000,     0, 32'h0,        4'b0000, 0, 1, 32'h00001234, 0);
    vecs[6]  = mk(OP_LOAD,  F3_BU, 32'h4000,     12'h7FF, 32'h0,        32'hA1B2C3D4, 1, 1,  32'h47FC,     0, 32'h0,        4'b0000, 0, 1, 32'h000000A1, 0);
    vecs[7]  = mk(OP_STORE, F3_H,  32'h200,      12'h002, 32'h5555BEEF, 32'h0,        1, 1,  32'h200,      1, 32'hBEEFBEEF, 4'b1100, 0, 0, 32'h0,        0);
    vecs[8]  = mk(OP_LOAD,  3'd3,  32'h600,      12'h000, 32'h0,        32'h0,        0, 0,  32'h0,        0, 32'h0,        4'b0000, 1, 0, 32'h0,        0);
    vecs[9]  = mk(OP_STORE, 3'd4,  32'h700,      12'h000, 32'h1,        32'h0,        0, 0,  32'h0,        0, 32'h0,        4'b0000, 1, 0, 32'h0,        0);
    vecs[10] = mk(OP_LOAD,  F3_W,  32'hFFFFFFFC, 12'h008, 32'h0,        32'h0BADC0DE, 1, 1,  32'h4,        0, 32'h0,        4'b0000, 0, 1, 32'h0BADC0DE, 0);
    vecs[11] = mk(OP_STORE, F3_B,  32'h21,       12'h000, 32'h12345677, 32'h0,        1, 1,  32'h20,       1, 32'h77777777, 4'b0010, 0, 0, 32'h0,        0);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // unknown opcode and stray ack while idle are both ignored
    opcode = 7'h13; funct3 = F3_W; base = 32'h9000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_opcode_busy", {31'b0, busy}, 32'd0);
    chk("bad_opcode_req", {31'b0, mem_req}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack_done", {31'b0, done | busy}, 32'd0);
    chk("idle_ack_reg_load", reg_load, cur_load);

    // reset while a store is waiting for ack
    opcode = OP_STORE; funct3 = F3_W; base = 32'h1000; imm12 = 12'h0; store_data = 32'h11223344;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_rst_req_before", {31'b0, mem_req}, 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_reg_load", reg_load, 32'd0);
    resetn = 1'b1;
    cur_load = 32'd0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("post_rst_done", {31'b0, done}, 32'd0);
    run_vec(100, vecs[1]);
    run_vec(101, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
